fp_mul_seq: RTL and testbench

- Sequential IEEE-754 single-precision multiplier. It is the multiplicative counterpart of the iterative divider `mydel` and sits alongside it in the calc datapath.
- Accepts two operands on a start pulse and runs a 24-step shift-add mantissa multiply.
- Normalises, packs and presents the result with a one-cycle done pulse.
- Latency is fixed and independent of the operand values.

---
 rtl/fp_mul_seq_if.sv | 14 +
 rtl/fp_mul_seq.sv | 126 ++++++++++++
 tb/tb_fp_mul_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_seq_if.sv
// Handshake and data bundle for the sequential single-precision multiplier.
// master: drives start/a/b, observes busy/done/res.
// slave : the multiplier itself.
interface fp_mul_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] res;

  modport master (output start, a, b, input busy, done, res);
  modport slave  (input start, a, b, output busy, done, res);
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier.
// Shift-add mantissa multiply, truncating rounding, denormals flushed to zero.
// Fixed latency: start at edge k gives done in the cycle after edge k+25.
// Ports: clk, rst_n (async active-low), bus (slave: start/a/b in, busy/done/res out).
// A start while busy is ignored; a start in the done cycle is accepted.
module fp_mul_seq #(
  parameter int          MANT_W = 24,
  parameter logic [31:0] QNAN   = 32'h7FC00000
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_mul_seq_if.slave    bus
);

  localparam logic [4:0] CNT_LAST = 5'(MANT_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

  state_t             state;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic               sign;
  logic signed [9:0]  exp_sum;
  logic [47:0]        mcand;
  logic [23:0]        mplier;
  logic [47:0]        acc;
  logic [4:0]         cnt;
  logic               busy_r;
  logic               done_r;
  logic [31:0]        res_r;

  // Operand classification on the latched operands.
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic signed [10:0] e_w;
  logic [22:0]        mant_w;
  logic [31:0]        packed_w;

  always_comb begin
    nan_a  = (&a_r[30:23]) && (|a_r[22:0]);
    nan_b  = (&b_r[30:23]) && (|b_r[22:0]);
    inf_a  = (&a_r[30:23]) && !(|a_r[22:0]);
    inf_b  = (&b_r[30:23]) && !(|b_r[22:0]);
    // Exponent field 0 covers both true zero and denormals (flushed).
    zero_a = !(|a_r[30:23]);
    zero_b = !(|b_r[30:23]);

    // Product of two [1,2) mantissas lies in [1,4): bit 47 says whether
    // it reached 2 and needs one extra exponent step.
    if (acc[47]) begin
      mant_w = acc[46:24];
      e_w    = 11'(exp_sum) - 11'sd126;
    end else begin
      mant_w = acc[45:23];
      e_w    = 11'(exp_sum) - 11'sd127;
    end

    if (nan_a || nan_b)
      packed_w = QNAN;
    else if ((inf_a && zero_b) || (inf_b && zero_a))
      packed_w = QNAN;
    else if (inf_a || inf_b)
      packed_w = {sign, 8'hFF, 23'h0};
    else if (zero_a || zero_b)
      packed_w = {sign, 31'h0};
    else if (e_w >= 11'sd255)
      packed_w = {sign, 8'hFF, 23'h0};
    else if (e_w <= 11'sd0)
      packed_w = {sign, 31'h0};
    else
      packed_w = {sign, e_w[7:0], mant_w};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sign    <= 1'b0;
      exp_sum <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      res_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            sign    <= bus.a[31] ^ bus.b[31];
            exp_sum <= $signed({2'b00, bus.a[30:23]} + {2'b00, bus.b[30:23]});
            mcand   <= (|bus.a[30:23]) ? {24'h0, 1'b1, bus.a[22:0]} : 48'h0;
            mplier  <= (|bus.b[30:23]) ? {1'b1, bus.b[22:0]} : 24'h0;
            acc     <= '0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= MUL;
          end
        end
        MUL: begin
          if (mplier[cnt])
            acc <= acc + (mcand << cnt);
          cnt <= cnt + 5'd1;
          if (cnt == CNT_LAST)
            state <= NORM;
        end
        NORM: begin
          res_r  <= packed_w;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.res  = res_r;

endmodule

// File: tb/tb_fp_mul_seq.sv
module tb_fp_mul_seq;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  fp_mul_seq_if bus ();

  fp_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: real-valued rules of the format, product via a plain multiply.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [22:0] fa, fb, m;
    logic [47:0] p;
    bit          za, zb, ia, ib;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);  eb = int'(b[30:23]);
    fa = a[22:0];         fb = b[22:0];
    za = (ea == 0);       zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC00000;
    if ((ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    p = {24'h0, 1'b1, fa} * {24'h0, 1'b1, fb};
    e = ea + eb - 127;
    if (p >= 48'h8000_0000_0000) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), m};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = $urandom_range(0, 11);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else               e = 8'($urandom_range(1, 254));
    f = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Called #1 after an edge; returns #1 after the acceptance edge with
  // operands scrambled so the DUT must have latched them.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Counts edges after acceptance until done; also counts busy-high cycles.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = bus.busy ? 1 : 0;
    while (!bus.done && n <= 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy) nbusy++;
    end
  endtask

  task automatic run_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int n, nb;
    start_op(a, b);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(n, nb);
    chk({tag, "_lat"}, 32'(n), 32'd25);
    chk({tag, "_res"}, bus.res, exp);
  endtask

  initial begin
    int          n, nb, dcount, dcyc;
    logic [31:0] dres, ra, rb;
    n_chk = 0;
    n_fail = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res",  bus.res, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 7 x 5 with busy duration check.
    start_op(32'h40E00000, 32'h40A00000);
    wait_done(n, nb);
    chk("m75_lat",  32'(n), 32'd25);
    chk("m75_busy_cycles", 32'(nb), 32'd25);
    chk("m75_res",  bus.res, 32'h420C0000);
    chk("m75_busy_done", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("m75_done_pulse", 32'(bus.done), 32'd0);
    chk("m75_res_hold", bus.res, 32'h420C0000);

    run_chk("neg",    32'h3FC00000, 32'hC0000000, 32'hC0400000);
    run_chk("trunc",  32'h3F800001, 32'h3F800001, 32'h3F800002);
    run_chk("zinf",   32'h00000000, 32'h7F800000, 32'h7FC00000);
    run_chk("ovf",    32'h7F000000, 32'h7F000000, 32'h7F800000);
    run_chk("unf",    32'h00800000, 32'h00800000, 32'h00000000);
    run_chk("nzero",  32'h80000000, 32'h40000000, 32'h80000000);
    run_chk("nan",    32'h7F800001, 32'h3F800000, 32'h7FC00000);

    // Start while busy is ignored; exactly one done.
    start_op(32'h40E00000, 32'h40A00000);
    dcount = 0; dcyc = 0; dres = '0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 10) begin
        bus.start = 1'b1;
        bus.a = 32'h3FC00000;
        bus.b = 32'h40000000;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        dcount++;
        dcyc = i;
        dres = bus.res;
      end
    end
    chk("ign_count", 32'(dcount), 32'd1);
    chk("ign_cycle", 32'(dcyc), 32'd25);
    chk("ign_res",   dres, 32'h420C0000);

    // Start in the done cycle is accepted with zero gap.
    start_op(32'h40E00000, 32'h40A00000);
    wait_done(n, nb);
    chk("b2b_first", bus.res, 32'h420C0000);
    run_chk("b2b_second", 32'h3FC00000, 32'h40000000, 32'h40400000);

    // Mid-operation reset aborts with no done.
    @(posedge clk); #1;
    start_op(32'h40E00000, 32'h40A00000);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_res",  bus.res, 32'h0);
    dcount = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
    end
    chk("arst_no_done", 32'(dcount), 32'd0);
    run_chk("arst_after", 32'h40E00000, 32'h40A00000, 32'h420C0000);

    // Randomized back-to-back chain against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      start_op(ra, rb);
      wait_done(n, nb);
      chk("rnd_lat", 32'(n), 32'd25);
      chk($sformatf("rnd_%h_x_%h", ra, rb), bus.res, ref_mul(ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
